// File: rtl/bpred_pkg.sv
// -----------------------------------------------------------------------------
// bpred_pkg
// Shared types and helpers for the bimodal BTB branch predictor.
//   pcnext_sel_e : encoding of the front-end PCnext mux select
//   DEF_*        : default geometry of the predictor
//   sat_update   : saturating +1/-1 used by direction counters and statistics
// -----------------------------------------------------------------------------
package bpred_pkg;

  typedef enum logic [1:0] {
    PC_IF_PLUS4 = 2'b00,  // sequential fetch
    PC_EX_PLUS4 = 2'b01,  // recover to fall-through of the committing branch
    PC_BTB_TGT  = 2'b10,  // follow the predicted BTB target
    PC_EX_TGT   = 2'b11   // recover to the resolved target
  } pcnext_sel_e;

  localparam int DEF_INDEX_WIDTH = 6;
  localparam int DEF_CTR_WIDTH   = 2;

  // Saturating step: increments toward max_val or decrements toward zero,
  // holding at either end instead of wrapping.
  function automatic logic [31:0] sat_update(input logic [31:0] val,
                                             input logic        inc,
                                             input logic [31:0] max_val);
    logic [31:0] res;
    res = val;
    if (inc) begin
      if (val != max_val) res = val + 32'd1;
    end else begin
      if (val != 32'd0) res = val - 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bimodal_btb_mem.sv
// -----------------------------------------------------------------------------
// bimodal_btb_mem
// Direct-mapped BTB storage: valid, tag, target, jmp bit and direction counter
// per entry. Asynchronous read; synchronous write with field-wise enables.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (clears valid/ctr)
//   i_rd_index          read index (IF)
//   o_rd_*              read data; only the counter MSB is exported
//   i_wr_index          write index (commit)
//   i_wr_alloc          full entry write: valid, tag, target, jmp, weak-taken ctr
//   i_wr_ctr_en/_inc    saturating counter step (inc=1 taken, 0 not taken)
//   i_wr_tgt_en         rewrite target only
//   i_wr_meta_en        rewrite tag and jmp bit
//   i_wr_tag/_target/_jmp  write data
// -----------------------------------------------------------------------------
module bimodal_btb_mem
  import bpred_pkg::*;
#(
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int CTR_WIDTH   = DEF_CTR_WIDTH,
  parameter int TW          = 32 - INDEX_WIDTH - 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [INDEX_WIDTH-1:0] i_rd_index,
  output logic                   o_rd_valid,
  output logic [TW-1:0]          o_rd_tag,
  output logic [31:0]            o_rd_target,
  output logic                   o_rd_jmp,
  output logic                   o_rd_ctr_msb,
  input  logic [INDEX_WIDTH-1:0] i_wr_index,
  input  logic                   i_wr_alloc,
  input  logic                   i_wr_ctr_en,
  input  logic                   i_wr_ctr_inc,
  input  logic                   i_wr_tgt_en,
  input  logic                   i_wr_meta_en,
  input  logic [TW-1:0]          i_wr_tag,
  input  logic [31:0]            i_wr_target,
  input  logic                   i_wr_jmp
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK_T = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
  localparam logic [31:0]          CTR_MAX    = 32'((64'd1 << CTR_WIDTH) - 64'd1);

  logic                 r_valid  [DEPTH];
  logic [CTR_WIDTH-1:0] r_ctr    [DEPTH];
  logic [TW-1:0]        r_tag    [DEPTH];
  logic [31:0]          r_target [DEPTH];
  logic                 r_jmp    [DEPTH];

  // NOTE: only valid and ctr are reset; tag/target/jmp are don't-care while
  // valid=0, so leaving them unreset lets them map onto plain RAM bits.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= '0;
      end
    end else if (i_wr_alloc) begin
      r_valid[i_wr_index] <= 1'b1;
      r_ctr[i_wr_index]   <= CTR_WEAK_T;
    end else if (i_wr_ctr_en) begin
      r_ctr[i_wr_index] <= CTR_WIDTH'(sat_update(32'(r_ctr[i_wr_index]),
                                                 i_wr_ctr_inc, CTR_MAX));
    end
  end

  // Reset suppresses any same-cycle commit write into the data fields too.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (i_wr_alloc || i_wr_meta_en) begin
        r_tag[i_wr_index] <= i_wr_tag;
        r_jmp[i_wr_index] <= i_wr_jmp;
      end
      if (i_wr_alloc || i_wr_tgt_en) begin
        r_target[i_wr_index] <= i_wr_target;
      end
    end
  end

  // Read returns pre-edge contents; a same-cycle write shows up next cycle.
  assign o_rd_valid   = r_valid[i_rd_index];
  assign o_rd_tag     = r_tag[i_rd_index];
  assign o_rd_target  = r_target[i_rd_index];
  assign o_rd_jmp     = r_jmp[i_rd_index];
  assign o_rd_ctr_msb = r_ctr[i_rd_index][CTR_WIDTH-1];

endmodule

// File: rtl/bimodal_btb_predictor.sv
// -----------------------------------------------------------------------------
// bimodal_btb_predictor
// Fetch-stage branch predictor: direct-mapped BTB with per-entry saturating
// direction counters. Predicts in IF from a combinational lookup; trains and
// detects mispredictions when a branch/jump commits in EXMEM.
// Optional statistics counters are enabled with `define BPRED_STATS_EN;
// otherwise stat_*_o are tied to zero.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   IF_PC_tag_i, IF_btb_rd_index_i            IF lookup address
//   EXMEM_*                 committing instruction, its prediction and outcome
//   IF_btb_hit_o, IF_pred_taken_o, IF_btb_rd_target_o   IF prediction
//   IF_PCnext_sel_o, IF_flush_o                          front-end steering
//   stat_br_cnt_o, stat_mispred_cnt_o                    statistics
// -----------------------------------------------------------------------------
module bimodal_btb_predictor
  import bpred_pkg::*;
#(
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int CTR_WIDTH   = DEF_CTR_WIDTH,
  localparam int TW         = 32 - INDEX_WIDTH - 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [TW-1:0]          IF_PC_tag_i,
  input  logic [INDEX_WIDTH-1:0] IF_btb_rd_index_i,
  input  logic                   EXMEM_valid_i,
  input  logic                   EXMEM_is_br_i,
  input  logic                   EXMEM_is_jmp_i,
  input  logic                   EXMEM_br_decision_i,
  input  logic                   EXMEM_pred_taken_i,
  input  logic [31:0]            EXMEM_pred_target_i,
  input  logic                   EXMEM_btb_hit_i,
  input  logic [INDEX_WIDTH-1:0] EXMEM_btb_wr_index_i,
  input  logic [TW-1:0]          EXMEM_btb_wr_tag_i,
  input  logic [31:0]            EXMEM_btb_wr_target_i,
  output logic                   IF_btb_hit_o,
  output logic                   IF_pred_taken_o,
  output logic [31:0]            IF_btb_rd_target_o,
  output logic [1:0]             IF_PCnext_sel_o,
  output logic                   IF_flush_o,
  output logic [31:0]            stat_br_cnt_o,
  output logic [31:0]            stat_mispred_cnt_o
);

  logic        w_rd_valid;
  logic [TW-1:0] w_rd_tag;
  logic        w_rd_jmp;
  logic        w_rd_ctr_msb;
  logic        w_cv;
  logic        w_mis_a;
  logic        w_mis_b;
  pcnext_sel_e w_sel;
  logic        w_flush;

  bimodal_btb_mem #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .CTR_WIDTH  (CTR_WIDTH),
    .TW         (TW)
  ) u_mem (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_rd_index   (IF_btb_rd_index_i),
    .o_rd_valid   (w_rd_valid),
    .o_rd_tag     (w_rd_tag),
    .o_rd_target  (IF_btb_rd_target_o),
    .o_rd_jmp     (w_rd_jmp),
    .o_rd_ctr_msb (w_rd_ctr_msb),
    .i_wr_index   (EXMEM_btb_wr_index_i),
    .i_wr_alloc   (w_cv && !EXMEM_btb_hit_i && EXMEM_br_decision_i),
    .i_wr_ctr_en  (w_cv && EXMEM_btb_hit_i && EXMEM_is_br_i),
    .i_wr_ctr_inc (EXMEM_br_decision_i),
    .i_wr_tgt_en  (w_cv && EXMEM_btb_hit_i && EXMEM_br_decision_i),
    .i_wr_meta_en (w_cv && EXMEM_btb_hit_i),
    .i_wr_tag     (EXMEM_btb_wr_tag_i),
    .i_wr_target  (EXMEM_btb_wr_target_i),
    .i_wr_jmp     (EXMEM_is_jmp_i)
  );

  assign IF_btb_hit_o    = w_rd_valid && (w_rd_tag == IF_PC_tag_i);
  assign IF_pred_taken_o = IF_btb_hit_o && (w_rd_jmp || w_rd_ctr_msb);

  // Bubbles and non-control instructions never train or flush.
  assign w_cv    = EXMEM_valid_i && (EXMEM_is_br_i || EXMEM_is_jmp_i);
  // A: predicted taken but fell through.
  assign w_mis_a = w_cv && EXMEM_pred_taken_i && !EXMEM_br_decision_i;
  // B: taken, but predicted not-taken or predicted the wrong target (JALR).
  assign w_mis_b = w_cv && EXMEM_br_decision_i &&
                   (!EXMEM_pred_taken_i ||
                    (EXMEM_pred_target_i != EXMEM_btb_wr_target_i));

  // NOTE: every output of this block is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_sel   = PC_IF_PLUS4;
    w_flush = 1'b0;
    if (!rst_i) begin
      if (w_mis_a) begin
        w_sel   = PC_EX_PLUS4;
        w_flush = 1'b1;
      end else if (w_mis_b) begin
        w_sel   = PC_EX_TGT;
        w_flush = 1'b1;
      end else if (IF_pred_taken_o) begin
        w_sel   = PC_BTB_TGT;
      end
    end
  end

  assign IF_PCnext_sel_o = w_sel;
  assign IF_flush_o      = w_flush;

`ifdef BPRED_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mis;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else begin
      if (w_cv)              r_stat_br  <= sat_update(r_stat_br, 1'b1, 32'hFFFF_FFFF);
      if (w_mis_a || w_mis_b) r_stat_mis <= sat_update(r_stat_mis, 1'b1, 32'hFFFF_FFFF);
    end
  end

  assign stat_br_cnt_o      = r_stat_br;
  assign stat_mispred_cnt_o = r_stat_mis;
`else
  assign stat_br_cnt_o      = '0;
  assign stat_mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bimodal_btb_predictor.sv
// -----------------------------------------------------------------------------
// tb_bimodal_btb_predictor
// Directed bench for bimodal_btb_predictor at INDEX_WIDTH=4, CTR_WIDTH=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units
// later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_bimodal_btb_predictor;

  localparam int IW = 4;
  localparam int TW = 32 - IW - 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [TW-1:0] IF_PC_tag_i;
  logic [IW-1:0] IF_btb_rd_index_i;
  logic          EXMEM_valid_i, EXMEM_is_br_i, EXMEM_is_jmp_i;
  logic          EXMEM_br_decision_i, EXMEM_pred_taken_i, EXMEM_btb_hit_i;
  logic [31:0]   EXMEM_pred_target_i, EXMEM_btb_wr_target_i;
  logic [IW-1:0] EXMEM_btb_wr_index_i;
  logic [TW-1:0] EXMEM_btb_wr_tag_i;
  logic          IF_btb_hit_o, IF_pred_taken_o, IF_flush_o;
  logic [31:0]   IF_btb_rd_target_o, stat_br_cnt_o, stat_mispred_cnt_o;
  logic [1:0]    IF_PCnext_sel_o;

  int n_checks = 0;
  int n_errors = 0;

`ifdef BPRED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  bimodal_btb_predictor #(.INDEX_WIDTH(IW), .CTR_WIDTH(2)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .IF_PC_tag_i           (IF_PC_tag_i),
    .IF_btb_rd_index_i     (IF_btb_rd_index_i),
    .EXMEM_valid_i         (EXMEM_valid_i),
    .EXMEM_is_br_i         (EXMEM_is_br_i),
    .EXMEM_is_jmp_i        (EXMEM_is_jmp_i),
    .EXMEM_br_decision_i   (EXMEM_br_decision_i),
    .EXMEM_pred_taken_i    (EXMEM_pred_taken_i),
    .EXMEM_pred_target_i   (EXMEM_pred_target_i),
    .EXMEM_btb_hit_i       (EXMEM_btb_hit_i),
    .EXMEM_btb_wr_index_i  (EXMEM_btb_wr_index_i),
    .EXMEM_btb_wr_tag_i    (EXMEM_btb_wr_tag_i),
    .EXMEM_btb_wr_target_i (EXMEM_btb_wr_target_i),
    .IF_btb_hit_o          (IF_btb_hit_o),
    .IF_pred_taken_o       (IF_pred_taken_o),
    .IF_btb_rd_target_o    (IF_btb_rd_target_o),
    .IF_PCnext_sel_o       (IF_PCnext_sel_o),
    .IF_flush_o            (IF_flush_o),
    .stat_br_cnt_o         (stat_br_cnt_o),
    .stat_mispred_cnt_o    (stat_mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_if(input logic [IW-1:0] idx, input logic [TW-1:0] tag);
    IF_btb_rd_index_i = idx;
    IF_PC_tag_i       = tag;
  endtask

  task automatic idle();
    EXMEM_valid_i         = 1'b0;
    EXMEM_is_br_i         = 1'b0;
    EXMEM_is_jmp_i        = 1'b0;
    EXMEM_br_decision_i   = 1'b0;
    EXMEM_pred_taken_i    = 1'b0;
    EXMEM_pred_target_i   = '0;
    EXMEM_btb_hit_i       = 1'b0;
    EXMEM_btb_wr_index_i  = '0;
    EXMEM_btb_wr_tag_i    = '0;
    EXMEM_btb_wr_target_i = '0;
  endtask

  task automatic commit(input logic br, input logic jmp, input logic dec,
                        input logic pt, input logic [31:0] ptgt, input logic hit,
                        input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                        input logic [31:0] tgt);
    EXMEM_valid_i         = 1'b1;
    EXMEM_is_br_i         = br;
    EXMEM_is_jmp_i        = jmp;
    EXMEM_br_decision_i   = dec;
    EXMEM_pred_taken_i    = pt;
    EXMEM_pred_target_i   = ptgt;
    EXMEM_btb_hit_i       = hit;
    EXMEM_btb_wr_index_i  = idx;
    EXMEM_btb_wr_tag_i    = tag;
    EXMEM_btb_wr_target_i = tgt;
  endtask

  // Commit one cycle and return to idle.
  task automatic commit_cycle(input logic br, input logic jmp, input logic dec,
                              input logic pt, input logic [31:0] ptgt, input logic hit,
                              input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                              input logic [31:0] tgt);
    commit(br, jmp, dec, pt, ptgt, hit, idx, tag, tgt);
    tick();
    idle();
  endtask

  initial begin
    idle();
    set_if(4'd3, 26'h1234);
    rst_i = 1'b1;
    tick();
    // Mispredicting commit during reset must not steer the front end.
    commit(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'd3, 26'h1234, 32'h100);
    settle();
    check("rst_sel", 32'(IF_PCnext_sel_o), 32'd0);
    check("rst_flush", 32'(IF_flush_o), 32'd0);
    tick();
    idle();
    rst_i = 1'b0;

    // 1. Cleared state.
    settle();
    check("t1_hit", 32'(IF_btb_hit_o), 32'd0);
    check("t1_pt", 32'(IF_pred_taken_o), 32'd0);
    check("t1_sel", 32'(IF_PCnext_sel_o), 32'd0);
    check("t1_flush", 32'(IF_flush_o), 32'd0);
    check("t1_stat_br", stat_br_cnt_o, 32'd0);
    check("t1_stat_mis", stat_mispred_cnt_o, 32'd0);

    // 2. Taken miss allocates; class B recovery.
    tick();
    commit(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'd3, 26'h1234, 32'h100);
    settle();
    check("t2_sel", 32'(IF_PCnext_sel_o), 32'd3);
    check("t2_flush", 32'(IF_flush_o), 32'd1);
    tick();
    idle();
    settle();
    check("t2_hit", 32'(IF_btb_hit_o), 32'd1);
    check("t2_pt", 32'(IF_pred_taken_o), 32'd1);
    check("t2_tgt", IF_btb_rd_target_o, 32'h100);
    check("t2_sel_btb", 32'(IF_PCnext_sel_o), 32'd2);
    set_if(4'd3, 26'h1235);
    settle();
    check("t2_tag_miss", 32'(IF_btb_hit_o), 32'd0);
    set_if(4'd3, 26'h1234);

    // 3. Not-taken with pred_taken=1: class A, ctr 10->01.
    tick();
    commit(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 4'd3, 26'h1234, 32'h100);
    settle();
    check("t3_sel_a", 32'(IF_PCnext_sel_o), 32'd1);
    check("t3_flush_a", 32'(IF_flush_o), 32'd1);
    tick();
    idle();
    settle();
    check("t3_hit", 32'(IF_btb_hit_o), 32'd1);
    check("t3_pt01", 32'(IF_pred_taken_o), 32'd0);
    check("t3_sel00", 32'(IF_PCnext_sel_o), 32'd0);
    commit(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd3, 26'h1234, 32'h100);
    settle();
    check("t3_noflush", 32'(IF_flush_o), 32'd0);
    check("t3_nosel", 32'(IF_PCnext_sel_o), 32'd0);
    tick();  // ctr 01->00
    commit_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd3, 26'h1234, 32'h100);  // hold 00
    commit_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd3, 26'h1234, 32'h100);  // hold 00
    commit_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 4'd3, 26'h1234, 32'h100);  // 00->01
    settle();
    check("t3_floor", 32'(IF_pred_taken_o), 32'd0);
    commit_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 4'd3, 26'h1234, 32'h100);  // 01->10
    settle();
    check("t3_up10", 32'(IF_pred_taken_o), 32'd1);
    commit_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 4'd3, 26'h1234, 32'h100); // 10->11
    commit_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 4'd3, 26'h1234, 32'h100); // hold 11
    commit_cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 4'd3, 26'h1234, 32'h100); // 11->10
    settle();
    check("t3_ceiling", 32'(IF_pred_taken_o), 32'd1);

    // 4. Jump bit forces taken even with a not-taken counter.
    set_if(4'd5, 26'h55);
    commit_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'd5, 26'h55, 32'h1F0);   // alloc ctr 10
    commit_cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h1F0, 1'b1, 4'd5, 26'h55, 32'h1F0); // ctr 01
    settle();
    check("t4_ctr01", 32'(IF_pred_taken_o), 32'd0);
    commit(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 4'd5, 26'h55, 32'h200);
    settle();
    check("t4_jmp_b", 32'(IF_PCnext_sel_o), 32'd3);
    tick();
    idle();
    settle();
    check("t4_jmp_pt", 32'(IF_pred_taken_o), 32'd1);
    check("t4_tgt200", IF_btb_rd_target_o, 32'h200);
    commit(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 4'd5, 26'h55, 32'h240);
    settle();
    check("t4_wrong_tgt_sel", 32'(IF_PCnext_sel_o), 32'd3);
    check("t4_wrong_tgt_flush", 32'(IF_flush_o), 32'd1);
    tick();
    idle();
    settle();
    check("t4_tgt240", IF_btb_rd_target_o, 32'h240);
    commit(1'b0, 1'b1, 1'b1, 1'b1, 32'h240, 1'b1, 4'd5, 26'h55, 32'h240);
    settle();
    check("t4_ok_sel", 32'(IF_PCnext_sel_o), 32'd2);
    check("t4_ok_flush", 32'(IF_flush_o), 32'd0);
    tick();
    idle();

    // 5. Same-cycle write and read at index 7.
    set_if(4'd7, 26'h77);
    commit_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'd7, 26'h77, 32'h300);
    commit(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 4'd7, 26'h77, 32'h380);
    settle();
    check("t5_old_tgt", IF_btb_rd_target_o, 32'h300);
    tick();
    idle();
    settle();
    check("t5_new_tgt", IF_btb_rd_target_o, 32'h380);
    set_if(4'd9, 26'h99);
    commit(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'd9, 26'h99, 32'h400);
    EXMEM_valid_i = 1'b0;
    settle();
    check("t5_bubble_flush", 32'(IF_flush_o), 32'd0);
    check("t5_bubble_sel", 32'(IF_PCnext_sel_o), 32'd0);
    tick();
    commit(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'd9, 26'h99, 32'h400);
    settle();
    check("t5_nonbr_flush", 32'(IF_flush_o), 32'd0);
    tick();
    idle();
    settle();
    check("t5_no_write", 32'(IF_btb_hit_o), 32'd0);

    // 6. Statistics: 10 commits, 3 mispredicts, bubbles in between.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    set_if(4'd10, 26'hA);
    commit_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 4'd10, 26'hA, 32'h500); // B
    commit_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 4'd10, 26'hA, 32'h500);
    commit_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 4'd10, 26'hA, 32'h500);
    tick();                                                                      // bubble
    commit_cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 4'd10, 26'hA, 32'h500); // A
    commit_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 4'd10, 26'hA, 32'h500);
    commit_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 4'd10, 26'hA, 32'h540); // B
    commit_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   1'b1, 4'd10, 26'hA, 32'h540); // non-branch
    for (int i = 0; i < 4; i++)
      commit_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h540, 1'b1, 4'd10, 26'hA, 32'h540);
    settle();
    check("t6_stat_br", stat_br_cnt_o, STATS ? 32'd10 : 32'd0);
    check("t6_stat_mis", stat_mispred_cnt_o, STATS ? 32'd3 : 32'd0);
    check("t6_hit_before_rst", 32'(IF_btb_hit_o), 32'd1);

    // Reset during a commit: counters clear and the allocation is dropped.
    rst_i = 1'b1;
    commit(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'd12, 26'hC, 32'h600);
    tick();
    rst_i = 1'b0;
    idle();
    settle();
    check("t6_rst_br", stat_br_cnt_o, 32'd0);
    check("t6_rst_mis", stat_mispred_cnt_o, 32'd0);
    check("t6_rst_clears", 32'(IF_btb_hit_o), 32'd0);
    set_if(4'd12, 26'hC);
    settle();
    check("t6_rst_nowrite", 32'(IF_btb_hit_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
